// File: rtl/poly_result_reader.sv
// poly_result_reader: walks the result RAM after start_i and streams masked words as packed beats.
module poly_result_reader #(
    parameter int N          = 17669,
    parameter int RAMWIDTH   = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BEAT_WIDTH = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] addr_result_o,
    output logic                  rd_dout_o,
    input  logic [RAMWIDTH-1:0]   dout_i,
    output logic [BEAT_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int NUM_WORDS = (N + RAMWIDTH - 1) / RAMWIDTH;
    localparam int WPB = BEAT_WIDTH / RAMWIDTH;
    localparam int NUM_BEATS = (NUM_WORDS + WPB - 1) / WPB;
    localparam int PW = $clog2(NUM_WORDS + 1);
    localparam int BW = $clog2(NUM_BEATS + 1);
    localparam int KW = $clog2(WPB + 1);
    localparam int REM = N % RAMWIDTH;
    localparam logic [RAMWIDTH-1:0] MASK = (REM == 0) ? {RAMWIDTH{1'b1}} : RAMWIDTH'((64'd1 << REM) - 64'd1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
    state_t state, next;

    logic [PW-1:0] ptr, left, nptr;
    logic [BW-1:0] beat;
    logic [KW-1:0] iss, k;
    logic [RD_LATENCY-1:0] vp, mp;
    logic [KW-1:0] lp [RD_LATENCY];
    logic hs, cap_last, last_beat, go;

    assign left      = PW'(NUM_WORDS) - ptr;
    assign k         = (left >= PW'(WPB)) ? KW'(WPB) : KW'(left);
    assign hs        = valid_o && ready_i;
    assign last_beat = beat == BW'(NUM_BEATS - 1);
    assign cap_last  = vp[RD_LATENCY-1] && lp[RD_LATENCY-1] == k - KW'(1);
    assign go        = state != FETCH && next == FETCH;
    assign nptr      = (state == IDLE) ? '0 : ptr + PW'(k);

    always_ff @(posedge clk) state <= rst ? IDLE : next;

    always_comb begin
        next = (state == IDLE)    ? (start_i ? FETCH : IDLE) :
               (state == FETCH)   ? (cap_last ? PRESENT : FETCH) :
               (state == PRESENT) ? (!hs ? PRESENT : last_beat ? DONE : FETCH) : IDLE;
    end

    always_comb begin
        valid_o = state == PRESENT;
        busy_o  = state == FETCH || state == PRESENT;
        done_o  = state == DONE;
        last_o  = valid_o && last_beat;
    end

    // vp/lp/mp track each issued read until its word returns RD_LATENCY cycles later
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            beat          <= '0;
            iss           <= '0;
            addr_result_o <= '0;
            rd_dout_o     <= 1'b0;
            data_o        <= '0;
            vp            <= '0;
            mp            <= '0;
            for (int i = 0; i < RD_LATENCY; i++) lp[i] <= '0;
        end else begin
            vp[0] <= rd_dout_o;
            mp[0] <= addr_result_o == ADDR_WIDTH'(NUM_WORDS - 1);
            lp[0] <= iss - KW'(1);
            for (int i = 1; i < RD_LATENCY; i++) begin
                vp[i] <= vp[i-1];
                mp[i] <= mp[i-1];
                lp[i] <= lp[i-1];
            end
            for (int i = 0; i < WPB; i++)
                if (vp[RD_LATENCY-1] && lp[RD_LATENCY-1] == KW'(i))
                    data_o[RAMWIDTH*i +: RAMWIDTH] <= dout_i & (mp[RD_LATENCY-1] ? MASK : {RAMWIDTH{1'b1}});
            if (go) begin
                ptr           <= nptr;
                beat          <= (state == IDLE) ? '0 : beat + BW'(1);
                addr_result_o <= ADDR_WIDTH'(nptr);
                rd_dout_o     <= 1'b1;
                iss           <= KW'(1);
                data_o        <= '0;
            end else if (state == FETCH && rd_dout_o && iss < k) begin
                addr_result_o <= addr_result_o + ADDR_WIDTH'(1);
                iss           <= iss + KW'(1);
            end else begin
                rd_dout_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_poly_result_reader.sv
// tb_poly_result_reader: random-ready scoreboard bench over three parameterisations of the reader.
module tb_poly_result_reader;
    localparam int NI = 3;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } beat_t;

    int nn  [NI] = '{17669, 17669, 128};
    int lat [NI] = '{1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst, start, ready, rd, valid, last, busy, done;
    logic [9:0]    addr  [NI];
    logic [31:0]   dout  [NI];
    logic [31:0]   r1    [NI];
    logic [31:0]   r2    [NI];
    logic [127:0]  data  [NI];
    logic [127:0]  pdata [NI];
    logic          pv [NI], prdy [NI], plast [NI];
    int            acc [NI] = '{default: 0};
    int            flen [NI] = '{default: 0};
    int            reads [NI][553];
    beat_t         exp_q [$];
    int            vectors = 0, errors = 0;

    poly_result_reader u0 (
        .clk(clk), .rst(rst[0]), .start_i(start[0]), .addr_result_o(addr[0]), .rd_dout_o(rd[0]),
        .dout_i(dout[0]), .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready[0]), .last_o(last[0]),
        .busy_o(busy[0]), .done_o(done[0]));
    poly_result_reader #(.RD_LATENCY(2)) u1 (
        .clk(clk), .rst(rst[1]), .start_i(start[1]), .addr_result_o(addr[1]), .rd_dout_o(rd[1]),
        .dout_i(dout[1]), .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready[1]), .last_o(last[1]),
        .busy_o(busy[1]), .done_o(done[1]));
    poly_result_reader #(.N(128)) u2 (
        .clk(clk), .rst(rst[2]), .start_i(start[2]), .addr_result_o(addr[2]), .rd_dout_o(rd[2]),
        .dout_i(dout[2]), .data_o(data[2]), .valid_o(valid[2]), .ready_i(ready[2]), .last_o(last[2]),
        .busy_o(busy[2]), .done_o(done[2]));

    function automatic logic [31:0] wfun(input int j);
        return 32'(j) * 32'h01010101;
    endfunction

    function automatic int nwf(input int g);
        return (nn[g] + 31) / 32;
    endfunction

    function automatic int nbf(input int g);
        return (nwf(g) + 3) / 4;
    endfunction

    function automatic int kexp(input int g, input int b);
        return (nwf(g) - 4 * b >= 4) ? 4 : nwf(g) - 4 * b;
    endfunction

    function automatic logic [159:0] outs(input int g);
        return {17'b0, addr[g], rd[g], data[g], valid[g], last[g], busy[g], done[g]};
    endfunction

    task automatic check(input bit ok, input string nm, input logic [159:0] act, input logic [159:0] want);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // RAM models: one or two register stages between address and data
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (rd[g]) r1[g] <= wfun(int'(addr[g]));
            r2[g] <= r1[g];
        end
    end
    assign dout[0] = r1[0];
    assign dout[1] = r2[1];
    assign dout[2] = r1[2];

    always @(negedge clk) begin
        beat_t e;
        for (int g = 0; g < NI; g++) begin
            if (rst[g]) begin
                acc[g]  = 0;
                flen[g] = 0;
                pv[g]   = 1'b0;
            end else begin
                if (rd[g]) begin
                    check(int'(addr[g]) < nwf(g), "addr_range", addr[g], nwf(g) - 1);
                    check(!valid[g], "rd_in_present", valid[g], 0);
                    if (int'(addr[g]) < 553) reads[g][addr[g]]++;
                end
                if (valid[g]) begin
                    if (!pv[g])
                        check(flen[g] == kexp(g, acc[g]) + lat[g], "fetch_len", flen[g], kexp(g, acc[g]) + lat[g]);
                    else if (!prdy[g])
                        check(data[g] == pdata[g] && last[g] == plast[g], "hold", {last[g], data[g]}, {plast[g], pdata[g]});
                    if (ready[g]) begin
                        if (exp_q.size() == 0) check(1'b0, "unexpected_beat", data[g], 0);
                        else begin
                            e = exp_q.pop_front();
                            check(data[g] === e.d, "beat_data", data[g], e.d);
                            check(last[g] === e.l, "beat_last", last[g], e.l);
                        end
                        acc[g]++;
                    end
                    flen[g] = 0;
                end else flen[g] = busy[g] ? flen[g] + 1 : 0;
                if (done[g]) acc[g] = 0;
                pv[g]    = valid[g];
                prdy[g]  = ready[g];
                pdata[g] = data[g];
                plast[g] = last[g];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g);
        beat_t b;
        logic [31:0] w;
        for (int bi = 0; bi < nbf(g); bi++) begin
            b.d = '0;
            for (int i = 0; i < 4; i++) begin
                int j = 4 * bi + i;
                if (j < nwf(g)) begin
                    w = wfun(j);
                    if (j == nwf(g) - 1 && nn[g] % 32 != 0) w = w & ((32'd1 << (nn[g] % 32)) - 32'd1);
                    b.d[32*i +: 32] = w;
                end
            end
            b.l = bi == nbf(g) - 1;
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_reads(input int g);
        for (int j = 0; j < 553; j++) reads[g][j] = 0;
    endtask

    task automatic pulse(input int g);
        start[g] = 1'b1;
        cyc();
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input bit rnd, input bit inj);
        bit p5 = 0, pl = 0, s;
        int n = 0;
        while (!done[g] && n < 20000) begin
            ready[g] = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            s = 0;
            if (inj && acc[g] == 5 && !p5) begin s = 1; p5 = 1; end
            if (inj && acc[g] == nbf(g) - 1 && !pl) begin s = 1; pl = 1; end
            start[g] = s;
            cyc();
            n++;
        end
        start[g] = 1'b0;
        ready[g] = 1'b1;
        check(done[g], "done_seen", done[g], 1);
    endtask

    task automatic post(input int g);
        int bad = 0;
        for (int j = 0; j < nwf(g); j++) if (reads[g][j] != 1) bad++;
        check(bad == 0, "reads_once", bad, 0);
        check(exp_q.size() == 0, "beats_left", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst = '1; start = '0; ready = '1;
        cyc(); cyc();
        for (int g = 0; g < NI; g++) check(outs(g) == '0, "reset_state", outs(g), 0);
        rst = '0;
        cyc();

        clear_reads(0); push(0); pulse(0);
        wait_done(0, 0, 0);
        post(0);
        cyc();
        check(!done[0] && !busy[0], "done_pulse", {done[0], busy[0]}, 0);

        clear_reads(0); push(0);
        start[0] = 1'b1; cyc(); start[0] = 1'b0;
        check(busy[0] && rd[0] && addr[0] == 10'd0, "fresh_start", {busy[0], rd[0], addr[0]}, {2'b11, 10'd0});
        wait_done(0, 0, 0);
        post(0);
        start[0] = 1'b1; cyc(); start[0] = 1'b0;
        check(!busy[0], "ignored_done_start", busy[0], 0);
        cyc(); cyc();
        check(!busy[0] && !rd[0], "still_idle", {busy[0], rd[0]}, 0);

        clear_reads(0); push(0); pulse(0);
        wait_done(0, 1, 1);
        post(0);
        cyc(); cyc();

        push(0); pulse(0);
        n = 0;
        while (!(acc[0] == 40 && busy[0] && !valid[0] && rd[0]) && n < 5000) begin cyc(); n++; end
        check(n < 5000, "reach_beat40", n, 5000);
        rst[0] = 1'b1; cyc(); rst[0] = 1'b0;
        check(outs(0) == '0, "reset_mid", outs(0), 0);
        exp_q.delete();
        cyc(); cyc();
        check(!busy[0] && !valid[0], "idle_after_reset", {busy[0], valid[0]}, 0);
        clear_reads(0); push(0); pulse(0);
        wait_done(0, 0, 0);
        post(0);

        clear_reads(1); push(1); pulse(1);
        wait_done(1, 0, 0);
        post(1);

        clear_reads(2); push(2); pulse(2);
        wait_done(2, 0, 0);
        post(2);
        cyc();
        check(!done[2], "done_pulse_n128", done[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
